// File: rtl/neural_network.sv
// Dense-layer accelerator: y = ReLU(W*x + b) in Q4.12, loaded and read over a
// simple memory-mapped port, one MAC per cycle with a two-stage fetch/MAC pipe.
module neural_network #(
    parameter int MM_DEPTH   = 16,
    parameter int MM_SIZE    = 16,
    parameter int Q_SIZE     = 16,
    parameter int FRAC_BITS  = 12,
    parameter int DATA_WORDS = 256,
    parameter int MAX_N      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write_enable,
    input  logic [MM_DEPTH-1:0] write_addr,
    input  logic [MM_SIZE-1:0]  write_data,
    input  logic [MM_DEPTH-1:0] read_addr,
    output logic [Q_SIZE-1:0]   read_data,
    output logic                busy
);

    localparam int ACC_W  = 40;
    localparam int PROD_W = 2 * Q_SIZE;
    localparam int DIDX_W = $clog2(DATA_WORDS);
    localparam int WIDX_W = $clog2(MAX_N * MAX_N);
    localparam int BIDX_W = $clog2(MAX_N);
    localparam int CNT_W  = $clog2(MAX_N) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    function automatic logic [Q_SIZE-1:0] sat_relu(input logic signed [ACC_W-1:0] v);
        logic [Q_SIZE-1:0] r;
        if (v[ACC_W-1]) begin
            r = {Q_SIZE{1'b0}};
        end else if (|v[ACC_W-2:Q_SIZE-1]) begin
            r = {1'b0, {(Q_SIZE-1){1'b1}}};
        end else begin
            r = v[Q_SIZE-1:0];
        end
        return r;
    endfunction

    logic [Q_SIZE-1:0] data_mem [DATA_WORDS];
    logic [Q_SIZE-1:0] wgt_mem  [MAX_N*MAX_N];
    logic [Q_SIZE-1:0] bias_mem [MAX_N];

    state_e                    state_q, state_d;
    logic                      busy_q, busy_d;
    logic [CNT_W-1:0]          n_q, cnt_q, row_q;
    logic [DIDX_W-1:0]         base_q;
    logic signed [Q_SIZE-1:0]  x_q, w_q;
    logic                      mac_vld_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [Q_SIZE-1:0]         read_data_q;

    logic [1:0]                region_s;
    logic                      host_we_s, start_s, fetch_s, wr_row_s;
    logic [CNT_W-1:0]          n_cmd_s;
    logic [DIDX_W-1:0]         x_idx_s, y_idx_s;
    logic [WIDX_W-1:0]         w_idx_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   sum_s;
    logic [Q_SIZE-1:0]         y_s;
    logic                      unused_s;

    assign unused_s  = ^{read_addr[MM_DEPTH-1:DIDX_W], write_addr[MM_DEPTH-3:WIDX_W]};
    assign region_s  = write_addr[MM_DEPTH-1 -: 2];
    assign n_cmd_s   = write_data[CNT_W-1:0];
    // Host writes are only taken while idle and out of reset.
    assign host_we_s = write_enable && reset && (state_q == S_IDLE);
    assign start_s   = host_we_s && (region_s == 2'b11) && (n_cmd_s != {CNT_W{1'b0}})
                       && (n_cmd_s <= CNT_W'(MAX_N));

    assign x_idx_s = base_q - DIDX_W'(n_q) + DIDX_W'(cnt_q);
    assign y_idx_s = base_q + DIDX_W'(row_q);
    assign w_idx_s = WIDX_W'(WIDX_W'(row_q) * WIDX_W'(n_q) + WIDX_W'(cnt_q));
    assign prod_s  = x_q * w_q;
    assign sum_s   = (acc_q >>> FRAC_BITS) + ACC_W'($signed(bias_mem[row_q[BIDX_W-1:0]]));
    assign y_s     = sat_relu(sum_s);

    assign read_data = read_data_q;
    assign busy      = busy_q;

    // State register and busy flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) state_d = S_FETCH;
                else         state_d = S_IDLE;
            end
            S_FETCH: begin
                if (cnt_q == n_q) state_d = S_WRITE;
                else              state_d = S_FETCH;
            end
            S_WRITE: begin
                if (row_q == n_q - CNT_W'(1'b1)) state_d = S_IDLE;
                else                             state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        fetch_s  = 1'b0;
        wr_row_s = 1'b0;
        busy_d   = (state_d != S_IDLE);
        case (state_q)
            S_FETCH: fetch_s  = (cnt_q != n_q);
            S_WRITE: wr_row_s = 1'b1;
            default: begin
                fetch_s  = 1'b0;
                wr_row_s = 1'b0;
            end
        endcase
    end

    // Datapath: command capture, operand fetch, MAC and host read port
    always_ff @(posedge clk) begin
        if (!reset) begin
            n_q         <= {CNT_W{1'b0}};
            base_q      <= {DIDX_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            row_q       <= {CNT_W{1'b0}};
            x_q         <= {Q_SIZE{1'b0}};
            w_q         <= {Q_SIZE{1'b0}};
            mac_vld_q   <= 1'b0;
            acc_q       <= {ACC_W{1'b0}};
            read_data_q <= {Q_SIZE{1'b0}};
        end else begin
            read_data_q <= data_mem[read_addr[DIDX_W-1:0]];
            if (start_s) begin
                n_q       <= n_cmd_s;
                base_q    <= write_addr[DIDX_W-1:0];
                cnt_q     <= {CNT_W{1'b0}};
                row_q     <= {CNT_W{1'b0}};
                mac_vld_q <= 1'b0;
                acc_q     <= {ACC_W{1'b0}};
            end else if (state_q == S_FETCH) begin
                // Operands fetched on cycle j are accumulated on cycle j+1.
                x_q       <= data_mem[x_idx_s];
                w_q       <= wgt_mem[w_idx_s];
                mac_vld_q <= fetch_s;
                cnt_q     <= cnt_q + CNT_W'(1'b1);
                if (mac_vld_q) begin
                    acc_q <= acc_q + ACC_W'(prod_s);
                end
            end else if (wr_row_s) begin
                cnt_q     <= {CNT_W{1'b0}};
                row_q     <= row_q + CNT_W'(1'b1);
                mac_vld_q <= 1'b0;
                acc_q     <= {ACC_W{1'b0}};
            end
        end
    end

    // Memory writes from host and row results; contents survive reset
    always_ff @(posedge clk) begin
        if (host_we_s) begin
            case (region_s)
                2'b00:   data_mem[write_addr[DIDX_W-1:0]] <= write_data;
                2'b01:   wgt_mem[write_addr[WIDX_W-1:0]]  <= write_data;
                2'b10:   bias_mem[write_addr[BIDX_W-1:0]] <= write_data;
                default: ;
            endcase
        end else if (wr_row_s && reset) begin
            data_mem[y_idx_s] <= y_s;
        end
    end

endmodule

// File: tb/tb_neural_network.sv
// Directed bench for neural_network: expected outputs are queued when a layer
// is launched and popped as each result word is read back.
module tb_neural_network;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_enable;
    logic [15:0] write_addr;
    logic [15:0] write_data;
    logic [15:0] read_addr;
    logic [15:0] read_data;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    localparam int LIMIT = 5000;

    always #5 clk = ~clk;

    neural_network dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        write_enable = 1'b1;
        write_addr   = a;
        write_data   = d;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        read_addr = a;
        @(negedge clk);
        v = read_data;
    endtask

    task automatic set_x(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2);
        wr(16'h0002, v0);
        wr(16'h0003, v1);
        wr(16'h0004, v2);
    endtask

    task automatic set_w(input logic [15:0] diag, input logic [15:0] off);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                wr(16'h4000 | 16'(i * 3 + j), (i == j) ? diag : off);
    endtask

    task automatic set_b(input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2);
        wr(16'h8000, b0);
        wr(16'h8001, b1);
        wr(16'h8002, b2);
    endtask

    task automatic start(input logic [7:0] d, input logic [5:0] n);
        wr({2'b11, 6'b000000, d}, {10'b0000000000, n});
    endtask

    task automatic run_layer(input logic [7:0] d, input logic [5:0] n, input bit lock, input string tag);
        int cnt;
        int exp_cyc;
        logic [15:0] v;
        logic [15:0] e;
        start(d, n);
        read_addr = 16'h0002;
        cnt = 0;
        while (busy === 1'b1 && cnt < LIMIT) begin
            cnt++;
            if (lock && cnt == 10) check({tag, "_read_in_busy"}, read_data, 16'h1000);
            write_enable = 1'b0;
            if (lock && cnt == 8) begin
                write_enable = 1'b1; write_addr = 16'hC005; write_data = 16'h0003;
            end
            if (lock && cnt == 12) begin
                write_enable = 1'b1; write_addr = 16'h0005; write_data = 16'h1234;
            end
            @(negedge clk);
        end
        write_enable = 1'b0;
        exp_cyc = int'(n) * (int'(n) + 2);
        check({tag, "_busy_cycles"}, cnt, exp_cyc);
        for (int i = 0; i < int'(n); i++) begin
            rd({8'h00, d + 8'(i)}, v);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
            check($sformatf("%s_y%0d", tag, i), v, e);
        end
    endtask

    initial begin
        logic [15:0] v;
        reset = 1'b0; write_enable = 1'b0;
        write_addr = 16'h0000; write_data = 16'h0000; read_addr = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_read_data", read_data, 16'h0000);
        reset = 1'b1;
        @(negedge clk);

        set_x(16'h1000, 16'h1000, 16'h1000);
        set_w(16'h1000, 16'h0000);
        set_b(16'h0000, 16'h0000, 16'h0000);
        exp_q.push_back(16'h1000); exp_q.push_back(16'h1000); exp_q.push_back(16'h1000);
        run_layer(8'd5, 6'd3, 1'b0, "identity");

        set_w(16'h1000, 16'h1000);
        exp_q.push_back(16'h3000); exp_q.push_back(16'h3000); exp_q.push_back(16'h3000);
        run_layer(8'd5, 6'd3, 1'b0, "ones");

        set_b(16'hC000, 16'hF000, 16'h1000);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h2000); exp_q.push_back(16'h4000);
        run_layer(8'd5, 6'd3, 1'b0, "bias_relu");

        set_x(16'h7FFF, 16'h7FFF, 16'h7FFF);
        set_w(16'h7FFF, 16'h7FFF);
        set_b(16'h0000, 16'h0000, 16'h0000);
        exp_q.push_back(16'h7FFF); exp_q.push_back(16'h7FFF); exp_q.push_back(16'h7FFF);
        run_layer(8'd5, 6'd3, 1'b0, "sat_pos");

        set_w(16'h8001, 16'h8001);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        run_layer(8'd5, 6'd3, 1'b0, "sat_neg");

        start(8'd5, 6'd0);
        check("n0_ignored", busy, 1'b0);
        start(8'd5, 6'd33);
        check("n33_ignored", busy, 1'b0);

        // Inputs wrap below address 0: x = data[255], data[0]; y -> data[1..2].
        wr(16'h00FF, 16'h2000);
        wr(16'h0000, 16'h0800);
        wr(16'h4000, 16'h1000); wr(16'h4001, 16'h1000);
        wr(16'h4002, 16'h2000); wr(16'h4003, 16'hF000);
        wr(16'h8000, 16'h0100); wr(16'h8001, 16'h0000);
        exp_q.push_back(16'h2900); exp_q.push_back(16'h3800);
        run_layer(8'd1, 6'd2, 1'b0, "wrap");

        set_x(16'h1000, 16'h1000, 16'h1000);
        set_w(16'h1000, 16'h1000);
        set_b(16'h0000, 16'h0000, 16'h0000);
        exp_q.push_back(16'h3000); exp_q.push_back(16'h3000); exp_q.push_back(16'h3000);
        run_layer(8'd5, 6'd3, 1'b1, "lockout");
        rd(16'h0005, v);
        check("lockout_data5", v, 16'h3000);
        check("lockout_idle_after", busy, 1'b0);

        read_addr = 16'h0002;
        start(8'd5, 6'd3);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", busy, 1'b0);
        check("midreset_read_data", read_data, 16'h0000);
        reset = 1'b1;
        @(negedge clk);
        rd(16'h0002, v); check("midreset_x0", v, 16'h1000);
        rd(16'h0003, v); check("midreset_x1", v, 16'h1000);
        rd(16'h0004, v); check("midreset_x2", v, 16'h1000);

        wr(16'h0005, 16'h0000); wr(16'h0006, 16'h0000); wr(16'h0007, 16'h0000);
        set_b(16'h1000, 16'h0000, 16'h0000);
        exp_q.push_back(16'h4000); exp_q.push_back(16'h3000); exp_q.push_back(16'h3000);
        run_layer(8'd5, 6'd3, 1'b0, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
